sudoku_frame_receiver: RTL and testbench
========================================

Name: sudoku_frame_receiver

Overview:
Decodes the game-state frame that the board serializer sends over UART, and rebuilds the same field set the display and memory paths consume: state, difficulty, board, colors, cursor, errors, selected number, victory, score and time. It sits after the UART RX byte deserializer and takes one byte per rx_valid strobe. It validates header, padding and XOR checksum, and updates its outputs atomically only on a good frame. It serves as the loopback/host-side counterpart of the transmit path.

Parameters:
TIMEOUT_CYCLES, 500000, maximum idle gap between bytes inside a frame (10 ms at 50 MHz) before the frame is aborted
SYNC_BYTE, 8'hA5, frame header byte

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
rx_error  in  1  UART framing/stop-bit error strobe
current_state  out  3  decoded game FSM state
game_dificulty  out  1  decoded difficulty
full_board  out  324  81 cells x 4 bits, cell 0 in [323:320]
colors  out  162  81 cells x 2 bits, cell 0 in [161:160]
position  out  8  {row[3:0], col[3:0]}
errors  out  2  error count
selected_number  out  4  selected digit
victory_condition  out  1  victory flag
score  out  7  score
time_in_seconds  out  11  elapsed time
frame_valid  out  1  one-cycle pulse: a good frame was committed
frame_error  out  1  one-cycle pulse: the frame was aborted (checksum, padding, rx_error, timeout)
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Frame layout (70 bytes, MSB-first):
  - B0: SYNC_BYTE
  - B1: {current_state, game_dificulty, errors, victory_condition, 1'b0}
  - B2: position
  - B3: {selected_number, 4'b0}
  - B4: {1'b0, score}
  - B5: {5'b0, time[10:8]}
  - B6: time[7:0]
  - B7..B47: {4'b0, full_board}, 41 bytes
  - B48..B68: {6'b0, colors}, 21 bytes
  - B69: XOR of B1..B68
- Reset: all outputs 0, state IDLE, byte counter 0, running checksum 0, timeout counter 0. Reset mid-frame discards the partial frame and raises no frame_error.
- FSM states and transitions:
  - IDLE: rx_valid with rx_data==SYNC_BYTE -> PAYLOAD, counter=0, checksum=0. Any other byte is ignored, with no error. rx_error in IDLE is ignored.
  - PAYLOAD: each rx_valid shifts the byte into a 544-bit shadow register, XORs it into the checksum and increments the counter. The 68th byte (counter==67) -> CHECK. A byte equal to SYNC_BYTE is treated as ordinary data.
  - CHECK: the next rx_valid byte is compared with the running checksum. A match with all pad bits zero (B1[0], B3[3:0], B4[7], B5[7:3], B7[7:4], B48[7:2]) -> commit. Any mismatch -> abort. Either way -> IDLE.
  - Commit: on the cycle after the checksum byte is accepted, all outputs load from the shadow register simultaneously and frame_valid pulses for 1 cycle. Latency from checksum strobe to outputs is 1 clk.
  - Abort: frame_error pulses 1 cycle, outputs keep their previous values, FSM -> IDLE.
- rx_error in PAYLOAD/CHECK causes an abort; if it arrives in the same cycle as rx_valid, the error wins.
- Timeout counter:
  - Clears on every rx_valid and increments while in PAYLOAD/CHECK.
  - Reaching TIMEOUT_CYCLES-1 causes an abort.
  - Held at 0 in IDLE.
  - Saturates; it never wraps.
- Back-to-back frames: a SYNC_BYTE in the cycle right after the checksum byte starts a new frame normally.
- frame_valid and frame_error are never high in the same cycle.

Decomposition:
- Package sudoku_uart_pkg holds SYNC_BYTE, FRAME_LEN=70, PAYLOAD_LEN=68, byte offsets (HDR_END=6, BOARD_FIRST=7, COLORS_FIRST=48, CKSUM=69), pad masks and the FSM state encoding. The transmit side shares the same package.
- One sub-module, rx_timeout_counter (clk, reset, clear, enable, expired), parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset then idle -> all outputs 0, busy=0, no pulses.
- Good frame: state=3'b101, dif=1, errors=2, victory=1, position=8'h58, selected=3, score=100, time=0, board=324'h0196...170, colors=162'b0010...1011; B1=8'hBA, B3=8'h30, B4=8'h64, correct checksum. Expected response:
  - frame_valid pulses exactly 1 clk after the checksum strobe.
  - All fields match the sent values.
  - busy drops in the same cycle.
- Repeat the good frame with the checksum XORed with 8'h01 -> frame_error pulse, outputs still hold the previous frame. Repeat with B3=8'h31 (pad bit set) -> frame_error.
- Garbage bytes 8'h00, 8'hFF, 8'h5A before the header, plus an 8'hA5 inside the board data -> frame still decodes and frame_valid pulses once.
- Byte gap of TIMEOUT_CYCLES after B20 (TIMEOUT_CYCLES=100 in the bench) -> frame_error. A following full frame decodes correctly.
- rx_error at B30 -> frame_error. Assert reset at B40 of the next frame -> outputs 0, no pulse. Then two back-to-back good frames -> two frame_valid pulses, and the second frame's values are visible.

Source files
------------

// File: rtl/sudoku_uart_pkg.sv
// Shared constants, frame layout and FSM encoding for the sudoku game-state UART link.
package sudoku_uart_pkg;

    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
    localparam int unsigned FRAME_LEN    = 70;
    localparam int unsigned PAYLOAD_LEN  = 68;
    localparam int unsigned HDR_END      = 6;
    localparam int unsigned BOARD_FIRST  = 7;
    localparam int unsigned COLORS_FIRST = 48;
    localparam int unsigned CKSUM        = 69;

    localparam int unsigned SHADOW_W     = PAYLOAD_LEN * 8;
    localparam int unsigned BOARD_W      = 324;
    localparam int unsigned COLORS_W     = 162;
    localparam int unsigned CNT_W        = 7;

    // Pad bits of B1..B68 as they sit in the shadow register (B1 in the MSBs)
    localparam logic [SHADOW_W-1:0] PAD_MASK =
        {8'h01, 8'h00, 8'h0F, 8'h80, 8'hF8, 8'h00, 4'hF, {BOARD_W{1'b0}}, 6'h3F, {COLORS_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } rx_state_e;

    // Payload bytes B1..B68, MSB-first, overlaid directly on the shadow register
    typedef struct packed {
        logic [2:0]          current_state;
        logic                game_dificulty;
        logic [1:0]          errors;
        logic                victory_condition;
        logic                pad_b1;
        logic [7:0]          position;
        logic [3:0]          selected_number;
        logic [3:0]          pad_b3;
        logic                pad_b4;
        logic [6:0]          score;
        logic [4:0]          pad_b5;
        logic [10:0]         time_in_seconds;
        logic [3:0]          pad_board;
        logic [BOARD_W-1:0]  full_board;
        logic [5:0]          pad_colors;
        logic [COLORS_W-1:0] colors;
    } game_frame_t;

    // True when any pad bit of the payload is set
    function automatic logic pad_bits_set(input game_frame_t f);
        return |(f & PAD_MASK);
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte idle counter: cleared by each byte, counts while enabled, saturates at the limit.
module rx_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Idle-gap counter, held at zero while disabled, never wraps
    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sudoku_frame_receiver.sv
// Decodes the 70-byte game-state UART frame and commits all fields atomically on a good frame.
module sudoku_frame_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         rx_error,
    output logic [2:0]   current_state,
    output logic         game_dificulty,
    output logic [323:0] full_board,
    output logic [161:0] colors,
    output logic [7:0]   position,
    output logic [1:0]   errors,
    output logic [3:0]   selected_number,
    output logic         victory_condition,
    output logic [6:0]   score,
    output logic [10:0]  time_in_seconds,
    output logic         frame_valid,
    output logic         frame_error,
    output logic         busy
);

    import sudoku_uart_pkg::*;

    rx_state_e           state_q, state_d;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic [7:0]          cksum_q;
    logic [SHADOW_W-1:0] shadow_q;
    game_frame_t         frame_c;
    logic                start_c, shift_c, commit_c, abort_c;
    logic                timeout_c;

    assign frame_c = game_frame_t'(shadow_q);

    rx_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_valid),
        .enable  (state_q != ST_IDLE),
        .expired (timeout_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle datapath controls; rx_error beats a same-cycle byte
    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        shift_c  = 1'b0;
        commit_c = 1'b0;
        abort_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    start_c = 1'b1;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (rx_error) begin
                    abort_c = 1'b1;
                end else if (rx_valid) begin
                    shift_c = 1'b1;
                    if (byte_cnt_q == CNT_W'(PAYLOAD_LEN - 1)) state_d = ST_CHECK;
                end else if (timeout_c) begin
                    abort_c = 1'b1;
                end
            end
            ST_CHECK: begin
                if (rx_error) begin
                    abort_c = 1'b1;
                end else if (rx_valid) begin
                    if (rx_data == cksum_q && !pad_bits_set(frame_c)) commit_c = 1'b1;
                    else                                              abort_c  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timeout_c) begin
                    abort_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_c) state_d = ST_IDLE;
    end

    // Shadow shift register, running checksum and byte counter
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            cksum_q    <= '0;
            shadow_q   <= '0;
        end else if (start_c) begin
            byte_cnt_q <= '0;
            cksum_q    <= '0;
        end else if (shift_c) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            cksum_q    <= cksum_q ^ rx_data;
            shadow_q   <= {shadow_q[SHADOW_W-9:0], rx_data};
        end
    end

    // Registered outputs: fields load together on commit, pulses last one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            current_state     <= '0;
            game_dificulty    <= 1'b0;
            full_board        <= '0;
            colors            <= '0;
            position          <= '0;
            errors            <= '0;
            selected_number   <= '0;
            victory_condition <= 1'b0;
            score             <= '0;
            time_in_seconds   <= '0;
            frame_valid       <= 1'b0;
            frame_error       <= 1'b0;
            busy              <= 1'b0;
        end else begin
            frame_valid <= commit_c;
            frame_error <= abort_c;
            busy        <= (state_d != ST_IDLE);
            if (commit_c) begin
                current_state     <= frame_c.current_state;
                game_dificulty    <= frame_c.game_dificulty;
                full_board        <= frame_c.full_board;
                colors            <= frame_c.colors;
                position          <= frame_c.position;
                errors            <= frame_c.errors;
                selected_number   <= frame_c.selected_number;
                victory_condition <= frame_c.victory_condition;
                score             <= frame_c.score;
                time_in_seconds   <= frame_c.time_in_seconds;
            end
        end
    end

endmodule

// File: tb/tb_sudoku_frame_receiver.sv
// Directed bench for sudoku_frame_receiver: good/bad frames, garbage, timeout, rx_error, reset, back-to-back.
module tb_sudoku_frame_receiver;

    localparam int unsigned TO = 100;

    logic         clk = 1'b0;
    logic         reset, rx_valid, rx_error;
    logic [7:0]   rx_data;
    logic [2:0]   current_state;
    logic         game_dificulty;
    logic [323:0] full_board;
    logic [161:0] colors;
    logic [7:0]   position;
    logic [1:0]   errors;
    logic [3:0]   selected_number;
    logic         victory_condition;
    logic [6:0]   score;
    logic [10:0]  time_in_seconds;
    logic         frame_valid, frame_error, busy;

    sudoku_frame_receiver #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .current_state(current_state), .game_dificulty(game_dificulty), .full_board(full_board),
        .colors(colors), .position(position), .errors(errors), .selected_number(selected_number),
        .victory_condition(victory_condition), .score(score), .time_in_seconds(time_in_seconds),
        .frame_valid(frame_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_fail = 0, n_fv = 0, n_fe = 0;
    int fv0, fe0;

    logic [7:0]   frame [70];
    logic [2:0]   e_state;
    logic         e_dif, e_vic;
    logic [1:0]   e_err;
    logic [7:0]   e_pos;
    logic [3:0]   e_sel;
    logic [6:0]   e_score;
    logic [10:0]  e_time;
    logic [323:0] e_board;
    logic [161:0] e_colors;

    // Pulse counters and the mutual-exclusion check
    always @(posedge clk) begin
        if (frame_valid) n_fv++;
        if (frame_error) n_fe++;
        if (frame_valid && frame_error) begin
            n_vec++;
            n_fail++;
            $error("FAIL pulse_excl: observed fv=1 fe=1 expected not both");
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [323:0] obs, input logic [323:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string pfx);
        check({pfx, "_state"}, 324'(current_state),     324'(e_state));
        check({pfx, "_dif"},   324'(game_dificulty),    324'(e_dif));
        check({pfx, "_board"}, full_board,              e_board);
        check({pfx, "_color"}, 324'(colors),            324'(e_colors));
        check({pfx, "_pos"},   324'(position),          324'(e_pos));
        check({pfx, "_err"},   324'(errors),            324'(e_err));
        check({pfx, "_sel"},   324'(selected_number),   324'(e_sel));
        check({pfx, "_vic"},   324'(victory_condition), 324'(e_vic));
        check({pfx, "_score"}, 324'(score),             324'(e_score));
        check({pfx, "_time"},  324'(time_in_seconds),   324'(e_time));
    endtask

    task automatic fix_cksum();
        logic [7:0] x;
        x = 8'h00;
        for (int k = 1; k <= 68; k++) x ^= frame[k];
        frame[69] = x;
    endtask

    task automatic build_frame();
        logic [543:0] p;
        p = {e_state, e_dif, e_err, e_vic, 1'b0, e_pos, e_sel, 4'b0, 1'b0, e_score,
             5'b0, e_time, 4'b0, e_board, 6'b0, e_colors};
        frame[0] = 8'hA5;
        for (int k = 1; k <= 68; k++) frame[k] = p[543 - 8*(k-1) -: 8];
        fix_cksum();
    endtask

    // Frame A: B1=8'hBA, B2=8'h58, B3=8'h30, B4=8'h64, B5=B6=8'h00
    task automatic set_a();
        e_state = 3'b101; e_dif = 1'b1; e_err = 2'd2; e_vic = 1'b1;
        e_pos = 8'h58; e_sel = 4'd3; e_score = 7'd100; e_time = 11'd0;
        for (int i = 0; i < 81; i++) begin
            e_board[323 - 4*i -: 4]  = 4'((i % 9) + 1);
            e_colors[161 - 2*i -: 2] = 2'(i % 4);
        end
    endtask

    // Frame B: max score/time, and board byte B8 equal to the sync byte
    task automatic set_b();
        e_state = 3'b010; e_dif = 1'b0; e_err = 2'd1; e_vic = 1'b0;
        e_pos = 8'h27; e_sel = 4'd9; e_score = 7'd127; e_time = 11'd2047;
        for (int i = 0; i < 81; i++) begin
            e_board[323 - 4*i -: 4]  = 4'((i * 7) % 10);
            e_colors[161 - 2*i -: 2] = 2'(3 - (i % 4));
        end
        e_board[319:312] = 8'hA5;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_byte(frame[k]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // Reset state
        e_state = '0; e_dif = 0; e_err = '0; e_vic = 0; e_pos = '0; e_sel = '0;
        e_score = '0; e_time = '0; e_board = '0; e_colors = '0;
        check_fields("rst");
        check("rst_busy", 324'(busy), 324'(0));
        check("rst_fv",   324'(frame_valid), 324'(0));
        check("rst_fe",   324'(frame_error), 324'(0));

        // Good frame A
        set_a(); build_frame();
        send_range(0, 68);
        check("a_busy_pre", 324'(busy), 324'(1));
        check("a_fv_pre",   324'(frame_valid), 324'(0));
        send_byte(frame[69]);
        check("a_fv",   324'(frame_valid), 324'(1));
        check("a_fe",   324'(frame_error), 324'(0));
        check("a_busy", 324'(busy), 324'(0));
        check_fields("a");
        idle(1);
        check("a_fv_drop", 324'(frame_valid), 324'(0));

        // Corrupted checksum: abort, outputs hold frame A
        frame[69] = frame[69] ^ 8'h01;
        send_range(0, 69);
        check("ck_fe", 324'(frame_error), 324'(1));
        check("ck_fv", 324'(frame_valid), 324'(0));
        check_fields("ck_hold");
        idle(1);
        check("ck_fe_drop", 324'(frame_error), 324'(0));

        // Pad bit set in B3 with a consistent checksum
        build_frame();
        frame[3] = 8'h31;
        fix_cksum();
        send_range(0, 69);
        check("pad_fe", 324'(frame_error), 324'(1));
        check("pad_score", 324'(score), 324'(100));
        idle(1);

        // Garbage before header, sync value inside board data
        set_b(); build_frame();
        fv0 = n_fv;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("gb_busy", 324'(busy), 324'(0));
        send_range(0, 69);
        check("gb_fv", 324'(frame_valid), 324'(1));
        check_fields("gb");
        idle(2);
        check("gb_fv_once", 324'(n_fv - fv0), 324'(1));

        // Idle gap after B20 long enough to time out
        set_a(); build_frame();
        fe0 = n_fe;
        send_range(0, 20);
        idle(TO + 5);
        check("to_fe_cnt", 324'(n_fe - fe0), 324'(1));
        check("to_busy",   324'(busy), 324'(0));
        check("to_hold_score", 324'(score), 324'(127));
        send_range(0, 69);
        check("to_next_fv", 324'(frame_valid), 324'(1));
        check_fields("to_next");
        idle(1);

        // Gap just under the timeout still decodes
        set_b(); build_frame();
        send_range(0, 20);
        idle(TO - 10);
        send_range(21, 69);
        check("gap_fv", 324'(frame_valid), 324'(1));
        check_fields("gap");
        idle(1);

        // rx_error together with B30
        set_a(); build_frame();
        send_range(0, 29);
        rx_error = 1'b1;
        send_byte(frame[30]);
        rx_error = 1'b0;
        check("rxe_fe", 324'(frame_error), 324'(1));
        check("rxe_fv", 324'(frame_valid), 324'(0));
        check("rxe_hold_time", 324'(time_in_seconds), 324'(2047));
        idle(1);

        // Reset at B40: outputs cleared, no pulse
        fv0 = n_fv; fe0 = n_fe;
        send_range(0, 39);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mr_busy",  324'(busy), 324'(0));
        check("mr_score", 324'(score), 324'(0));
        check("mr_board", full_board, 324'(0));
        check("mr_state", 324'(current_state), 324'(0));
        idle(3);
        check("mr_no_fv", 324'(n_fv - fv0), 324'(0));
        check("mr_no_fe", 324'(n_fe - fe0), 324'(0));

        // Back-to-back frames A then B
        fv0 = n_fv;
        set_a(); build_frame();
        send_range(0, 69);
        set_b(); build_frame();
        send_range(0, 69);
        check("bb_fv", 324'(frame_valid), 324'(1));
        check_fields("bb");
        idle(1);
        check("bb_fv_cnt", 324'(n_fv - fv0), 324'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
